// File: rtl/sopc_data_bus_if.sv
// Data-side bus bundle between the CPU data port, the interconnect and its slaves.
// "slave" is the interconnect's view (CPU's slave); "master" is the environment's view.
interface sopc_data_bus_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  // Handshake: the master raises m_ce_i with a stable request and holds it while
  // m_stall_o=1; the response (m_data_o/m_err_o) is valid only in the cycle stall drops.
  // A slave sees s_ce_o[i]=1 until it returns s_ack_i[i]=1 with s_data_i for reads.
  logic                         m_ce_i;
  logic                         m_we_i;
  logic [DATA_W/8-1:0]          m_sel_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W-1:0]            m_data_i;
  logic [DATA_W-1:0]            m_data_o;
  logic                         m_stall_o;
  logic                         m_err_o;
  logic [NUM_SLAVES-1:0]        s_ce_o;
  logic                         s_we_o;
  logic [DATA_W/8-1:0]          s_sel_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W-1:0]            s_data_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_data_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;

  modport slave (
    input  m_ce_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    output m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_sel_o, s_addr_o, s_data_o
  );

  modport master (
    output m_ce_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    input  m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_sel_o, s_addr_o, s_data_o
  );
endinterface

// File: rtl/sopc_data_bus.sv
// Multi-slave data bus for the OpenMIPS SOPC: address decode, ack handshake with wait states.
// Optional bus timeout compiled in with `define SOPC_BUS_TIMEOUT_EN.
module sopc_data_bus #(
  parameter int                           NUM_SLAVES     = 4,
  parameter int                           ADDR_W         = 32,
  parameter int                           DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                            32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {4{32'hF000_0000}},
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  sopc_data_bus_if.slave       bus,
  output logic [1:0]           state_dbg
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int SEL_W = DATA_W / 8;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              we_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              ack;

`ifdef SOPC_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign ack = bus.s_ack_i[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef SOPC_BUS_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_ce_i) begin
            we_q   <= bus.m_we_i;
            sel_q  <= bus.m_sel_i;
            addr_q <= bus.m_addr_i;
            data_q <= bus.m_data_i;
            idx    <= hit_idx;
            if (hit) begin
              state <= WAIT;
`ifdef SOPC_BUS_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= RESP;
            end
          end
        end
        WAIT: begin
          // Ack is tested first so a late ack beats a simultaneous timeout.
          if (ack) begin
            rdata_q <= we_q ? '0 : bus.s_data_i[idx*DATA_W +: DATA_W];
            err_q   <= 1'b0;
            state   <= RESP;
          end
`ifdef SOPC_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_ce_o = '0;
    if (state == WAIT) bus.s_ce_o[idx] = 1'b1;
  end

  assign bus.m_stall_o = (state == IDLE) ? bus.m_ce_i : (state == WAIT);
  assign bus.m_data_o  = (state == RESP) ? rdata_q : '0;
  assign bus.m_err_o   = (state == RESP) && err_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_sel_o   = sel_q;
  assign bus.s_addr_o  = addr_q;
  assign bus.s_data_o  = data_q;
  assign state_dbg     = state;
endmodule

// File: doc/sopc_data_bus.md
# sopc_data_bus

Parametrised data-side interconnect for the OpenMIPS SOPC: connects the CPU data-memory port to NUM_SLAVES memory-mapped slaves (data RAM, peripherals) through an address decoder, a request/acknowledge handshake with variable wait states, and an optional bus-timeout error path. It sits between the core's ram_* port and the slaves. It generalises the fixed single-RAM, zero-wait data path into a multi-slave, stall-capable bus.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- SLAVE_BASE, {0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, packed NUM_SLAVES*ADDR_W, base of slave i at bits [i*ADDR_W +: ADDR_W]
- SLAVE_MASK, {4{0xF000_0000}}, packed NUM_SLAVES*ADDR_W, decode mask per slave
- TIMEOUT_CYCLES, 255, WAIT cycles before bus error (when timeout compiled in)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- m_ce_i  in  1  master request valid
- m_we_i  in  1  1 = write, 0 = read
- m_sel_i  in  DATA_W/8  byte enables
- m_addr_i  in  ADDR_W  address
- m_data_i  in  DATA_W  write data
- m_data_o  out  DATA_W  read data, valid in RESP only
- m_stall_o  out  1  stall to CPU pipeline
- m_err_o  out  1  bus error, valid in RESP only
- s_ce_o  out  NUM_SLAVES  one-hot slave select
- s_we_o, s_sel_o, s_addr_o, s_data_o  out  1/DATA_W/8/ADDR_W/DATA_W  broadcast latched request
- s_data_i  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- s_ack_i  in  NUM_SLAVES  slave acknowledge

## Operation
- Decode: slave i hits when (m_addr_i & MASK_i) == (BASE_i & MASK_i); lowest index wins on overlap; no hit = decode miss.
- FSM states IDLE, WAIT, RESP.
- IDLE: m_stall_o = m_ce_i (combinational). On m_ce_i=1 latch we/sel/addr/data and slave index; hit -> WAIT; miss -> RESP with err=1, rdata=0.
- WAIT: s_ce_o[idx]=1, s_* driven from latched registers; m_stall_o=1. On s_ack_i[idx]=1: rdata <= s_data_i[idx] for reads, 0 for writes; err=0; -> RESP. Acks from non-selected slaves ignored.
- RESP: one cycle; m_stall_o=0, m_data_o=rdata, m_err_o=err; -> IDLE unconditionally. s_ce_o=0.
- Outside RESP, m_data_o=0 and m_err_o=0.
- Master holds request stable while m_stall_o=1. If m_ce_i drops during WAIT, transaction still completes; response discarded by master.
- A new request is seen earliest in the IDLE cycle following RESP; no back-to-back acceptance.

## Timing
- Reset (rst=0, async): state=IDLE, s_ce_o=0, s_we_o=0, s_sel_o=0, s_addr_o=0, s_data_o=0, m_data_o=0, m_err_o=0, m_stall_o=0 (while m_ce_i=0), timeout counter=0.
- Minimum access: 3 cycles (IDLE accept, WAIT with same-cycle ack, RESP). Each wait state adds one WAIT cycle.
- Decode miss: 2 cycles (IDLE, RESP).
- Reset mid-WAIT: slave select drops immediately; transaction abandoned, no RESP.
- Timeout counter clears on entering WAIT, increments each WAIT cycle without ack; ack in the same cycle the count reaches TIMEOUT_CYCLES wins (normal response).

## Configuration
- SOPC_BUS_TIMEOUT_EN defined: in WAIT, after TIMEOUT_CYCLES cycles without ack -> RESP with err=1, rdata=0; s_ce_o drops on RESP entry.
- Not defined: no counter; WAIT persists until ack; m_err_o asserts only on decode miss.

## Test plan
- Read 0x0000_0010, slave0 acks same cycle with 0xDEADBEEF -> s_ce_o=0001 one cycle, RESP in cycle 2 with m_data_o=0xDEADBEEF, m_err_o=0, stall high cycles 0-1.
- Write 0x2000_0004 data 0x12345678 sel 1100, slave2 acks after 3 wait states -> s_ce_o=0100 for 4 cycles with s_data_o=0x12345678, s_sel_o=1100; RESP m_data_o=0, m_err_o=0.
- Read 0x4000_0000 (unmapped) -> no s_ce_o, RESP in cycle 1 with m_err_o=1, m_data_o=0.
- With SOPC_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave1 never acks -> RESP after 8 WAIT cycles, m_err_o=1; without macro stall stays high for 100+ cycles.
- SLAVE_MASK0=0, ack from slave3 during slave0 WAIT -> slave0 selected for every address, stray slave3 ack ignored.
- rst pulled low during WAIT -> all outputs at reset values asynchronously, next request after release completes normally.
